// File: rtl/vec_store_ctrl.sv
// Vector store sequencer: packs the low byte of 16 ALU lanes into a 128-bit vector
// and writes it to data memory as four acknowledged 32-bit beats.
module vec_store_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [15:0][31:0]      alu_res,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

    state_t              state, state_nx;
    logic [1:0]          beat;
    logic [127:0]        pack_q, pack_d;
    logic [ADDR_W-1:0]   base;
    logic                aligned;
    logic                accept;

    assign aligned = (st_addr[1:0] == 2'b00);
    assign accept  = (state == IDLE) && st_valid && aligned;

    // Lane 0 lands in the most significant byte.
    always_comb begin
        pack_d = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            pack_d[8*(15-i) +: 8] = alu_res[i][7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            base   <= '0;
            beat   <= '0;
        end else if (accept) begin
            pack_q <= pack_d;
            base   <= st_addr;
            beat   <= '0;
        end else if ((state == WRITE) && mem_ack && (beat != 2'd3)) begin
            beat <= beat + 2'd1;
        end
    end

    always_comb begin
        state_nx  = state;
        st_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    state_nx = aligned ? WRITE : ERR;
                end
            end
            WRITE: begin
                mem_we   = 1'b1;
                busy     = 1'b1;
                mem_addr = base + ADDR_W'(ADDR_STEP) * ADDR_W'(beat);
                case (beat)
                    2'd0:    mem_wdata = pack_q[127:96];
                    2'd1:    mem_wdata = pack_q[95:64];
                    2'd2:    mem_wdata = pack_q[63:32];
                    default: mem_wdata = pack_q[31:0];
                endcase
                if (mem_ack && (beat == 2'd3)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                err      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/vec_store_ctrl.md
Name: vec_store_ctrl

Overview:
- Sequences a 16-lane SIMD ALU result into data memory as one 128-bit vector store, issued as four 32-bit write beats.
- Packs the low byte of each 32-bit lane with lane 0 most significant, latches the packed vector and base address on a request handshake, then drives the memory write port beat by beat with per-beat acknowledge stalls.
- Sits between the vector ALU writeback stage and the data-memory write port.
- Reports completion or a misaligned-address error to the pipeline control.

Parameters:
- ADDR_W, 32, byte-address width of st_addr and mem_addr.
- ADDR_STEP, 4, byte increment between consecutive beats.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- st_valid  input  1  store request valid.
- st_ready  output  1  controller can accept a request; high only in IDLE.
- st_addr  input  ADDR_W  byte base address of the store.
- alu_res  input  16x32 (packed [15:0][31:0])  lane results; only bits [7:0] of each lane are stored.
- mem_we  output  1  write beat valid.
- mem_addr  output  ADDR_W  beat byte address.
- mem_wdata  output  32  beat data.
- mem_ack  input  1  memory accepted the current beat; ignored while mem_we=0.
- busy  output  1  high in WRITE and DONE.
- done  output  1  one-cycle pulse after the last beat is accepted.
- err  output  1  one-cycle pulse on a misaligned request.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, beat=0, packed/base registers=0.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, st_ready=1.
- Reset mid-operation aborts the store immediately:
  - mem_we drops with rst_n and no done is produced.
  - The partial memory contents are left as written.
- Packing: packed = {alu_res[0][7:0], alu_res[1][7:0], …, alu_res[15][7:0]}, so lane 0 occupies bits [127:120]. Bits [31:8] of each lane are don't-care.
- States: IDLE, WRITE, DONE, ERR. Every output is decoded from registered state only; no combinational path runs from mem_ack or st_valid to any output.
- IDLE:
  - st_ready=1.
  - On st_valid=1 with st_addr[1:0]==0: latch packed and base=st_addr, set beat=0, go to WRITE.
  - On st_valid=1 with st_addr[1:0]!=0: go to ERR; nothing is latched and no write is issued.
- WRITE:
  - mem_we=1.
  - mem_addr = base + ADDR_STEP*beat, modulo 2^ADDR_W (wrap-around permitted, no error).
  - mem_wdata = packed[127-32*beat -: 32].
  - mem_we, mem_addr and mem_wdata hold stable until mem_ack=1 is sampled.
  - On mem_ack with beat<3: beat++. On mem_ack with beat==3: go to DONE.
- DONE: done=1 for exactly one cycle, mem_we=0, st_ready=0, then IDLE.
- ERR: err=1 for exactly one cycle, st_ready=0, busy=0, then IDLE.
- Back-to-back requests: the earliest next handshake is the cycle after DONE/ERR (one IDLE cycle minimum). A request held during busy is accepted once IDLE is reached.
- Latency with mem_ack tied high:
  - Handshake at cycle T.
  - Beats at T+1..T+4.
  - done at T+5.
  - st_ready high again at T+6.
- Input isolation: alu_res and st_addr changes after the handshake do not affect the store in progress.

Test Plan:
- Basic store: set alu_res[i]=32'hAB000000|(i*8'h11), st_addr=32'h100, mem_ack=1 -> beats (0x100,0x00112233), (0x104,0x44556677), (0x108,0x8899AABB), (0x10C,0xCCDDEEFF); done at T+5; st_ready at T+6.
- Stalls: same stimulus, mem_ack low 3 cycles on beat 1 -> mem_addr=0x104 and mem_wdata=0x44556677 held steady for 4 cycles; no beat is skipped or duplicated; done at T+8.
- Misaligned: st_addr=32'h102 -> err pulses 1 cycle at T+1, mem_we stays 0, done never asserts, st_ready=1 at T+2.
- Address wrap: st_addr=32'hFFFFFFF8 -> mem_addr sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004; done asserts normally.
- Reset mid-store: assert rst_n=0 during beat 2 -> mem_we=0 and busy=0 asynchronously; no done; after release, st_ready=1 and a new store completes correctly.
- Input isolation plus back-to-back: change alu_res to all-zero after the handshake -> written data is unchanged; st_valid held high -> second store accepted at T+6 with the new data.
